// File: rtl/williams_vid_timing.sv
// Williams SoC video timing regenerator: pixel/line counters rebuilt from raw
// hs/vs, blanking windows, 1-clock aligned video and a line-length lock detector.

module williams_vid_timing #(
  parameter int CNT_W      = 11,
  parameter int HB_START   = 336,
  parameter int HB_END     = 40,
  parameter int VB_START   = 256,
  parameter int VB_END     = 16,
  parameter int LOCK_LINES = 4,
  parameter int TOL        = 2
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [7:0]       rgb_in,
  output logic             ce_pix,
  output logic             hblank,
  output logic             vblank,
  output logic [CNT_W-2:0] hcnt,
  output logic [CNT_W-1:0] vcnt,
  output logic [7:0]       rgb_out,
  output logic             hs_out,
  output logic             vs_out,
  output logic             locked,
  output logic [CNT_W-1:0] line_len
);

  localparam int               MW     = $clog2(LOCK_LINES + 2);
  localparam logic [MW-1:0]    LOCK_M = MW'(LOCK_LINES);
  localparam logic [CNT_W:0]   TOL_W  = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-2:0] HB_S   = (CNT_W - 1)'(HB_START);
  localparam logic [CNT_W-2:0] HB_E   = (CNT_W - 1)'(HB_END);
  localparam logic [CNT_W-1:0] VB_S   = CNT_W'(VB_START);
  localparam logic [CNT_W-1:0] VB_E   = CNT_W'(VB_END);

  typedef struct packed {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
  } vid_t;

  logic [CNT_W-1:0] pcnt_d, pcnt_q;
  logic [CNT_W-1:0] lcnt_d, lcnt_q;
  logic [CNT_W-1:0] line_len_d, line_len_q;
  logic [MW-1:0]    match_cnt_d, match_cnt_q;
  logic             old_hs_d, old_hs_q;
  logic             old_vs_d, old_vs_q;
  logic             hblank_d, hblank_q;
  logic             vblank_d, vblank_q;
  logic             locked_d, locked_q;
  vid_t             vid_d, vid_q;

  logic             hs_edge, vs_edge, pcnt_sat, len_match;
  logic [CNT_W:0]   len_diff, len_abs;
  logic [MW-1:0]    match_inc;

  assign hs_edge   = ~old_hs_q & hs_in;
  assign vs_edge   = ~old_vs_q & vs_in;
  assign pcnt_sat  = &pcnt_q;
  // Signed distance between this line and the last one, folded to magnitude.
  assign len_diff  = {1'b0, pcnt_q} - {1'b0, line_len_q};
  assign len_abs   = len_diff[CNT_W] ? -len_diff : len_diff;
  assign len_match = (len_abs <= TOL_W);
  assign match_inc = match_cnt_q + MW'(1);

  always_comb begin
    pcnt_d      = pcnt_sat ? pcnt_q : pcnt_q + CNT_W'(1);
    lcnt_d      = lcnt_q;
    old_hs_d    = hs_in;
    old_vs_d    = old_vs_q;
    line_len_d  = line_len_q;
    match_cnt_d = match_cnt_q;
    locked_d    = locked_q;
    hblank_d    = hblank_q;
    vblank_d    = vblank_q;
    vid_d       = '{rgb: rgb_in, hs: hs_in, vs: vs_in};

    // Windows compare the pre-update counters, so a line-start reset of pcnt
    // never masks a compare on the same clock.
    if (pcnt_q[CNT_W-1:1] == HB_S)      hblank_d = 1'b1;
    else if (pcnt_q[CNT_W-1:1] == HB_E) hblank_d = 1'b0;
    if (lcnt_q == VB_S)                 vblank_d = 1'b1;
    else if (lcnt_q == VB_E)            vblank_d = 1'b0;

    if (hs_edge) begin
      pcnt_d     = '0;
      old_vs_d   = vs_in;
      lcnt_d     = vs_edge ? '0 : ((&lcnt_q) ? lcnt_q : lcnt_q + CNT_W'(1));
      line_len_d = pcnt_q;
      if (pcnt_sat) begin
        match_cnt_d = '0;
        locked_d    = 1'b0;
      end else if (len_match) begin
        match_cnt_d = (match_inc >= LOCK_M) ? LOCK_M : match_inc;
        if (match_inc >= LOCK_M) locked_d = 1'b1;
      end else begin
        match_cnt_d = '0;
        locked_d    = 1'b0;
      end
    end else if (pcnt_sat) begin
      // hs has gone missing for a whole counter span
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pcnt_q      <= '0;
      lcnt_q      <= '0;
      line_len_q  <= '0;
      match_cnt_q <= '0;
      old_hs_q    <= 1'b0;
      old_vs_q    <= 1'b0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      locked_q    <= 1'b0;
      vid_q       <= '0;
    end else begin
      pcnt_q      <= pcnt_d;
      lcnt_q      <= lcnt_d;
      line_len_q  <= line_len_d;
      match_cnt_q <= match_cnt_d;
      old_hs_q    <= old_hs_d;
      old_vs_q    <= old_vs_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      locked_q    <= locked_d;
      vid_q       <= vid_d;
    end
  end

  assign ce_pix   = pcnt_q[0];
  assign hcnt     = pcnt_q[CNT_W-1:1];
  assign vcnt     = lcnt_q;
  assign hblank   = hblank_q | ~locked_q;
  assign vblank   = vblank_q | ~locked_q;
  assign locked   = locked_q;
  assign line_len = line_len_q;
  assign rgb_out  = vid_q.rgb;
  assign hs_out   = vid_q.hs;
  assign vs_out   = vid_q.vs;

endmodule

// File: tb/tb_williams_vid_timing.sv
// Randomized-video bench for williams_vid_timing against an integer-level
// reference model of the counters, windows and lock rules.

module tb_williams_vid_timing;
  localparam int CNT_W      = 11;
  localparam int MAXC       = (1 << CNT_W) - 1;
  localparam int HB_START   = 336;
  localparam int HB_END     = 40;
  localparam int VB_START   = 256;
  localparam int VB_END     = 16;
  localparam int LOCK_LINES = 4;
  localparam int TOL        = 2;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             hs_in   = 1'b0;
  logic             vs_in   = 1'b0;
  logic [7:0]       rgb_in  = 8'h00;
  logic             ce_pix, hblank, vblank, hs_out, vs_out, locked;
  logic [CNT_W-2:0] hcnt;
  logic [CNT_W-1:0] vcnt, line_len;
  logic [7:0]       rgb_out;

  always #5 clk_sys = ~clk_sys;

  williams_vid_timing #(
    .CNT_W(CNT_W), .HB_START(HB_START), .HB_END(HB_END), .VB_START(VB_START),
    .VB_END(VB_END), .LOCK_LINES(LOCK_LINES), .TOL(TOL)
  ) u_dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .hs_in(hs_in), .vs_in(vs_in),
    .rgb_in(rgb_in), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
    .hcnt(hcnt), .vcnt(vcnt), .rgb_out(rgb_out), .hs_out(hs_out),
    .vs_out(vs_out), .locked(locked), .line_len(line_len)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integers; "run" is the unbounded count of
  // consecutive in-tolerance line lengths.
  int   m_pcnt, m_lcnt, m_len, run, edges;
  bit   m_old_hs, m_old_vs, m_locked, m_hb, m_vb, m_hs, m_vs;
  logic [7:0] m_rgb;

  task automatic model_reset();
    m_pcnt = 0; m_lcnt = 0; m_len = 0; run = 0; edges = 0;
    m_old_hs = 0; m_old_vs = 0; m_locked = 0; m_hb = 1; m_vb = 1;
    m_hs = 0; m_vs = 0; m_rgb = 8'h00;
  endtask

  task automatic model_step();
    bit hs_rise;
    int d;
    hs_rise = !m_old_hs && hs_in;
    if (m_pcnt / 2 == HB_START) m_hb = 1; else if (m_pcnt / 2 == HB_END) m_hb = 0;
    if (m_lcnt == VB_START) m_vb = 1; else if (m_lcnt == VB_END) m_vb = 0;
    if (hs_rise) begin
      edges++;
      d = m_pcnt - m_len;
      if (d < 0) d = -d;
      if (m_pcnt == MAXC) run = 0;
      else if (d <= TOL)  run++;
      else                run = 0;
      m_locked = (run >= LOCK_LINES);
      m_len = m_pcnt;
      if (!m_old_vs && vs_in) m_lcnt = 0;
      else if (m_lcnt < MAXC) m_lcnt++;
      m_old_vs = vs_in;
      m_pcnt = 0;
    end else if (m_pcnt == MAXC) begin
      m_locked = 0;
    end else begin
      m_pcnt++;
    end
    m_old_hs = hs_in; m_rgb = rgb_in; m_hs = hs_in; m_vs = vs_in;
  endtask

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) model_reset();
    else          model_step();
  end

  task automatic compare_all();
    chk("hcnt",     32'(hcnt),     32'(m_pcnt / 2));
    chk("ce_pix",   32'(ce_pix),   32'(m_pcnt % 2));
    chk("vcnt",     32'(vcnt),     32'(m_lcnt));
    chk("hblank",   32'(hblank),   32'(m_hb || !m_locked));
    chk("vblank",   32'(vblank),   32'(m_vb || !m_locked));
    chk("locked",   32'(locked),   32'(m_locked));
    chk("line_len", 32'(line_len), 32'(m_len));
    chk("rgb_out",  32'(rgb_out),  32'(m_rgb));
    chk("hs_out",   32'(hs_out),   32'(m_hs));
    chk("vs_out",   32'(vs_out),   32'(m_vs));
  endtask

  bit lock_seen = 0;
  int lock_at   = -1;

  // One clock: sample at the falling edge, then drive the next inputs.
  task automatic tick(input bit h, input bit v);
    @(negedge clk_sys);
    compare_all();
    if (reset_n && locked === 1'b1 && !lock_seen) begin
      lock_seen = 1;
      lock_at   = edges;
    end
    hs_in  = h;
    vs_in  = v;
    rgb_in = 8'($urandom);
  endtask

  // Line of len clocks, hs high for the first 64, vs high over [va,vb).
  task automatic line(input int len, input int va, input int vb, input int from);
    for (int i = from; i < len; i++) tick(i < 64, i >= va && i < vb);
  endtask

  int v0;

  initial begin
    // reset with toggling inputs
    for (int i = 0; i < 20; i++) tick(1'($urandom), 1'($urandom));
    tick(0, 0);
    chk("rst_hblank",   32'(hblank),   32'd1);
    chk("rst_vblank",   32'(vblank),   32'd1);
    chk("rst_locked",   32'(locked),   32'd0);
    chk("rst_rgb",      32'(rgb_out),  32'd0);
    chk("rst_line_len", 32'(line_len), 32'd0);
    reset_n = 1'b1;

    // steady 768-clock lines
    repeat (766) tick(0, 0);
    line(768, 0, 768, 0);
    for (int k = 1; k < 12; k++) line(768, 0, 0, 0);
    chk("lock_edge",  32'(lock_at),  32'd5);
    chk("len_767",    32'(line_len), 32'd767);
    chk("locked_a",   32'(locked),   32'd1);

    // hblank edges inside a locked line
    for (int i = 0; i < 768; i++) begin
      tick(i < 64, 0);
      if (i == 81)  chk("hb_fall_pre", 32'(hblank), 32'd1);
      if (i == 82)  chk("hb_fall",     32'(hblank), 32'd0);
      if (i == 673) chk("hb_rise_pre", 32'(hblank), 32'd0);
      if (i == 674) chk("hb_rise",     32'(hblank), 32'd1);
    end

    // jitter within tolerance, then one bad line
    for (int k = 0; k < 8; k++) line((k % 2) ? 769 : 767, 0, 0, 0);
    chk("jitter_locked", 32'(locked), 32'd1);
    line(780, 0, 0, 0);
    tick(1, 0);
    tick(1, 0);
    chk("bad_unlock", 32'(locked), 32'd0);
    chk("bad_hblank", 32'(hblank), 32'd1);
    chk("bad_vblank", 32'(vblank), 32'd1);
    line(768, 0, 0, 2);
    for (int k = 0; k < 6; k++) line(768, 0, 0, 0);
    chk("relock", 32'(locked), 32'd1);

    // sync loss
    v0 = m_lcnt;
    repeat (2500) tick(0, 0);
    chk("sat_hcnt",   32'(hcnt),   32'd1023);
    chk("sat_ce",     32'(ce_pix), 32'd1);
    chk("sat_unlock", 32'(locked), 32'd0);
    chk("sat_vcnt",   32'(vcnt),   32'(v0));
    tick(1, 0);
    tick(1, 0);
    chk("restart_hcnt", 32'(hcnt),     32'd0);
    chk("restart_len",  32'(line_len), 32'(MAXC));
    line(768, 0, 0, 2);

    // vs pulse between hs edges, then vs held across an edge
    line(200, 0, 0, 0);
    v0 = m_lcnt;
    line(200, 100, 150, 0);
    tick(1, 0);
    tick(1, 0);
    chk("vs_mid_ignored", 32'(vcnt), 32'(v0 + 2));
    line(200, 150, 200, 2);
    tick(1, 1);
    tick(1, 1);
    chk("vs_held_zero", 32'(vcnt), 32'd0);
    line(200, 0, 10, 2);
    tick(1, 0);
    tick(1, 0);
    chk("vs_next_one", 32'(vcnt), 32'd1);
    line(200, 0, 0, 2);

    // vblank window over short-line frames
    line(90, 0, 90, 0);
    for (int k = 1; k <= 258; k++) begin
      line(90, 0, 0, 0);
      if (k == 100) chk("vb_mid_off", 32'(vblank), 32'd0);
    end
    chk("vb_on",     32'(vblank), 32'd1);
    chk("vb_locked", 32'(locked), 32'd1);
    line(90, 0, 0, 0);
    line(90, 0, 90, 0);
    for (int k = 1; k <= 20; k++) line(90, 0, 0, 0);
    chk("vb_off", 32'(vblank), 32'd0);

    // reset mid-frame
    for (int k = 0; k < 6; k++) line(768, 0, 0, 0);
    line(300, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_hblank", 32'(hblank), 32'd1);
    chk("mid_rst_vblank", 32'(vblank), 32'd1);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    repeat (5) tick(0, 0);
    lock_seen = 0;
    lock_at   = -1;
    reset_n   = 1'b1;
    repeat (766) tick(0, 0);
    for (int k = 0; k < 8; k++) line(768, 0, 0, 0);
    chk("mid_rst_lock_edge", 32'(lock_at), 32'd5);
    chk("mid_rst_relock",    32'(locked),  32'd1);
    tick(0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/williams_vid_timing.md
Name: williams_vid_timing

Overview:
- Sits directly downstream of the Williams SoC video outputs and directly upstream of the arcade video/scaler stage.
- Regenerates horizontal and vertical counters from the SoC's raw hs/vs.
- Produces the pixel enable, HBlank/VBlank windows, 1-cycle-aligned RGB/sync, and a line-length lock detector.
- When timing is not locked (ROM download, reset, garbage sync), blanking is forced so the scaler never sees a malformed frame.

Parameters:
- CNT_W, 11, width of pixel and line counters.
- HB_START, 336, pcnt[CNT_W-1:1] value at which hblank asserts.
- HB_END, 40, pcnt[CNT_W-1:1] value at which hblank deasserts.
- VB_START, 256, line count at which vblank asserts.
- VB_END, 16, line count at which vblank deasserts.
- LOCK_LINES, 4, consecutive matching lines required to assert locked.
- TOL, 2, allowed |line_len - prev_len| in clocks for a line to "match".

Ports:
- clk_sys  in  1  system clock (12 MHz class; two clocks per pixel).
- reset_n  in  1  asynchronous, active-low reset.
- hs_in  in  1  SoC hsync, active-high pulse.
- vs_in  in  1  SoC vsync, active-high.
- rgb_in  in  8  SoC colour {r[2:0],g[2:0],b[1:0]}.
- ce_pix  out  1  pixel enable, equal to pcnt[0].
- hblank  out  1  horizontal blank.
- vblank  out  1  vertical blank.
- hcnt  out  CNT_W-1  pcnt[CNT_W-1:1], the pixel index.
- vcnt  out  CNT_W  line counter.
- rgb_out  out  8  rgb_in delayed 1 clock.
- hs_out  out  1  hs_in delayed 1 clock.
- vs_out  out  1  vs_in delayed 1 clock.
- locked  out  1  line timing is stable.
- line_len  out  CNT_W  pcnt value captured at the last hs rising edge.

Behaviour:
- Reset (reset_n=0, async):
  - pcnt=0, lcnt=0, old_hs=0, old_vs=0.
  - hblank_r=1, vblank_r=1, locked=0, line_len=0, prev_len=0, match_cnt=0.
  - rgb_out=0, hs_out=0, vs_out=0.
  - Deassertion takes effect on the next clk_sys edge.
- All state is registered on posedge clk_sys. old_hs<=hs_in every cycle.
- pcnt:
  - Increments each cycle; saturates at all-ones (no wrap).
  - hs edge = ~old_hs & hs_in. On an hs edge, pcnt<=0 (the edge has priority over the increment).
- Line counter, updated only on an hs edge:
  - lcnt increments, saturating at all-ones.
  - old_vs<=vs_in.
  - If ~old_vs & vs_in, lcnt<=0 (overrides the increment).
  - vs_in changes between hs edges are ignored until the next hs edge.
- Blank registers:
  - hblank_r: set when pcnt[CNT_W-1:1]==HB_START; cleared when ==HB_END. Otherwise it holds.
  - vblank_r: set when lcnt==VB_START; cleared when lcnt==VB_END.
  - Comparisons use the current (pre-update) counter values, so the effect is 1 cycle after the count is reached.
- Outputs:
  - hblank = hblank_r | ~locked.
  - vblank = vblank_r | ~locked.
  - ce_pix = pcnt[0]. hcnt = pcnt[CNT_W-1:1]. vcnt = lcnt.
  - rgb_out, hs_out and vs_out are 1-cycle registered copies, aligned with the blank registers.
- Lock detector, evaluated on each hs edge with L = current pcnt:
  - line_len<=L and prev_len<=line_len.
  - If pcnt is saturated: match_cnt<=0 and locked<=0.
  - Else if |L - line_len| <= TOL: match_cnt<=min(match_cnt+1, LOCK_LINES), and locked<=1 when match_cnt+1 >= LOCK_LINES.
  - Else: match_cnt<=0 and locked<=0.
  - The difference is computed unsigned at CNT_W+1 bits with a sign check.
- Saturation while locked: if pcnt reaches all-ones with no hs edge, locked<=0 that cycle (hs lost).
- Simultaneous hs edge and hblank compare: the compare uses the pre-edge pcnt; the counter reset does not suppress it.
- Reset mid-frame: all blanks go high immediately (async). Lock re-acquires after LOCK_LINES+1 hs edges.

Test Plan:
- Reset: hold reset_n=0 with toggling inputs -> hblank=1, vblank=1, locked=0, rgb_out=0, line_len=0.
- Steady 768-clock lines (hs pulse at 0..63), vs every 260 lines -> line_len=767, locked rises on the 5th hs edge after reset release.
- Blank windows with lock:
  - hblank rises 1 clk after hcnt==336 and falls 1 clk after hcnt==40.
  - vblank rises at vcnt==256 and falls at vcnt==16.
  - rgb_out equals rgb_in delayed by exactly 1 clk.
- Jitter: alternate 767/769-clock lines -> locked stays 1. Inject one 780-clock line -> locked=0 at that edge, hblank/vblank forced 1, relock after 4 good lines.
- Sync loss: stop hs for more than 2048 clks -> pcnt saturates at 2047, locked=0. vcnt holds. Restart hs -> pcnt resets to 0.
- vs pulse entirely between two hs edges -> lcnt not reset. vs held across an hs edge -> lcnt=0 on that edge and counts 1 on the next.
